// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: drains the encoder input FIFO and packs
// FRAME_WORDS words into one frame on a valid/ready port.
module fifo_frame_reader #(
  parameter int WIDTH       = 8,
  parameter int FRAME_WORDS = 4,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fifo_rempty,
  output logic                         fifo_rinc,
  input  logic [WIDTH-1:0]             fifo_rdata,
  input  logic                         flush,
  output logic                         frm_valid,
  input  logic                         frm_ready,
  output logic [WIDTH*FRAME_WORDS-1:0] frm_data,
  output logic [CNT_W-1:0]             frm_drop
);

  localparam int CW = $clog2(FRAME_WORDS + 1);
  localparam int FW = WIDTH * FRAME_WORDS;
  localparam logic [CW-1:0] FULL = CW'(FRAME_WORDS);
  localparam logic [CW-1:0] LAST = CW'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     issue_q, issue_d;
  logic [CW-1:0]     cap_q, cap_d;
  logic              pend_q, pend_d;
  logic [FW-1:0]     data_q, data_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              hs;

  // Pop only while filling, words remain and no flush; held off in reset.
  assign fifo_rinc = ~rst
                   & (state_q == FILL)
                   & ~fifo_rempty
                   & (issue_q < FULL)
                   & ~flush;

  assign frm_valid = (state_q == HOLD);
  assign frm_data  = data_q;
  assign frm_drop  = drop_q;
  assign hs        = frm_valid & frm_ready;

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      issue_q <= '0;
      cap_q   <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      cap_q   <= cap_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  // Next state: handshake beats flush, flush beats fill progress.
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    cap_d   = cap_q;
    pend_d  = 1'b0;
    data_d  = data_q;
    drop_d  = drop_q;
    if (hs) begin
      state_d = FILL;
      issue_d = '0;
      cap_d   = '0;
    end else if (flush) begin
      state_d = FILL;
      issue_d = '0;
      cap_d   = '0;
      if ((issue_q != '0) || (state_q == HOLD)) begin
        if (drop_q != SAT) begin
          drop_d = drop_q + CNT_W'(1);
        end
      end
    end else begin
      if (fifo_rinc) begin
        issue_d = issue_q + CW'(1);
      end
      pend_d = fifo_rinc;
      if (pend_q) begin
        for (int k = 0; k < FRAME_WORDS; k++) begin
          if (cap_q == CW'(k)) begin
            data_d[k*WIDTH +: WIDTH] = fifo_rdata;
          end
        end
        cap_d = cap_q + CW'(1);
        if (cap_q == LAST) begin
          state_d = HOLD;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: directed bench with a behavioural FIFO
// read port and a frame monitor.
module tb_fifo_frame_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_rempty;
  logic        fifo_rinc;
  logic [7:0]  fifo_rdata;
  logic        flush;
  logic        frm_valid;
  logic        frm_ready;
  logic [31:0] frm_data;
  logic [15:0] frm_drop;

  logic [7:0]  mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  int          cyc = 0;
  int          rinc_n = 0;
  int          last_rinc = 0;
  int          vcyc = 0;
  int          nfr = 0;
  logic [31:0] frames [0:31];
  int          fcyc [0:31];
  bit          ovr = 1'b0;

  int          n_chk = 0;
  int          n_pass = 0;

  fifo_frame_reader #(
    .WIDTH(8),
    .FRAME_WORDS(4),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fifo_rempty(fifo_rempty),
    .fifo_rinc(fifo_rinc),
    .fifo_rdata(fifo_rdata),
    .flush(flush),
    .frm_valid(frm_valid),
    .frm_ready(frm_ready),
    .frm_data(frm_data),
    .frm_drop(frm_drop)
  );

  always #5 clk = ~clk;

  assign fifo_rempty = (rd_ptr == wr_ptr);

  // FIFO read port with one-cycle registered data, plus monitor.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rinc) begin
      if (rd_ptr == wr_ptr) ovr <= 1'b1;
      fifo_rdata <= mem[rd_ptr[5:0]];
      rd_ptr     <= rd_ptr + 1;
      rinc_n     <= rinc_n + 1;
      last_rinc  <= cyc;
    end
    if (frm_valid) vcyc <= vcyc + 1;
    if (frm_valid && frm_ready) begin
      frames[nfr[4:0]] <= frm_data;
      fcyc[nfr[4:0]]   <= cyc;
      nfr              <= nfr + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[5:0]] = d;
    wr_ptr++;
  endtask

  task automatic wait_nfr(input string tag, input int n);
    int i;
    i = 0;
    while (nfr < n && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 64'(nfr >= n), 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    int i;
    i = 0;
    while (!frm_valid && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 64'(frm_valid), 64'd1);
  endtask

  initial begin
    int br, bf, bv, chg;
    logic [31:0] snap;
    rst = 1'b1;
    flush = 1'b0;
    frm_ready = 1'b1;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    @(negedge clk);
    chk("rst_valid", 64'(frm_valid), 64'd0);
    chk("rst_rinc", 64'(fifo_rinc), 64'd0);
    chk("rst_data", 64'(frm_data), 64'd0);
    chk("rst_drop", 64'(frm_drop), 64'd0);

    // 1: preloaded frame, ready high
    br = rinc_n; bf = nfr; bv = vcyc;
    rst = 1'b0;
    #1 chk("t1_rinc0", 64'(fifo_rinc), 64'd1);
    wait_nfr("t1_to", bf + 1);
    chk("t1_data", 64'(frames[bf]), 64'h04030201);
    chk("t1_lat", 64'(fcyc[bf] - last_rinc), 64'd2);
    chk("t1_pops", 64'(rinc_n - br), 64'd4);
    repeat (3) @(negedge clk);
    chk("t1_vcyc", 64'(vcyc - bv), 64'd1);

    // 2: back-pressure holds the frame
    frm_ready = 1'b0;
    br = rinc_n; bf = nfr;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    wait_valid("t2_to");
    snap = frm_data;
    chg = 0;
    repeat (10) begin
      @(negedge clk);
      if (frm_data !== snap || !frm_valid) chg++;
    end
    chk("t2_stable", 64'(chg), 64'd0);
    chk("t2_hold", 64'(frm_data), 64'h13121110);
    chk("t2_pops", 64'(rinc_n - br), 64'd4);
    frm_ready = 1'b1;
    wait_nfr("t2_to2", bf + 2);
    chk("t2_f0", 64'(frames[bf]), 64'h13121110);
    chk("t2_f1", 64'(frames[bf + 1]), 64'h17161514);

    // 3: FIFO runs dry mid-frame
    br = rinc_n; bf = nfr;
    push(8'hAA); push(8'hBB);
    repeat (6) @(negedge clk);
    chk("t3_nofrm", 64'(nfr - bf), 64'd0);
    chk("t3_pops", 64'(rinc_n - br), 64'd2);
    push(8'hCC); push(8'hDD);
    wait_nfr("t3_to", bf + 1);
    chk("t3_data", 64'(frames[bf]), 64'hDDCCBBAA);
    chk("t3_drop", 64'(frm_drop), 64'd0);

    // 4: flush with a word in flight
    br = rinc_n; bf = nfr;
    push(8'h21); push(8'h22); push(8'h23);
    @(negedge clk);
    @(negedge clk);
    chk("t4_pops", 64'(rinc_n - br), 64'd2);
    flush = 1'b1;
    #1 chk("t4_norinc", 64'(fifo_rinc), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("t4_drop", 64'(frm_drop), 64'd1);
    push(8'h24); push(8'h25); push(8'h26);
    wait_nfr("t4_to", bf + 1);
    chk("t4_data", 64'(frames[bf]), 64'h26252423);

    // 5a: flush in HOLD without ready
    frm_ready = 1'b0;
    bf = nfr;
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    wait_valid("t5a_to");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5a_valid", 64'(frm_valid), 64'd0);
    chk("t5a_drop", 64'(frm_drop), 64'd2);
    chk("t5a_nofrm", 64'(nfr - bf), 64'd0);

    // 5b: flush coincident with handshake
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    wait_valid("t5b_to");
    frm_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5b_dlv", 64'(nfr - bf), 64'd1);
    chk("t5b_data", 64'(frames[bf]), 64'h44434241);
    chk("t5b_drop", 64'(frm_drop), 64'd2);
    chk("t5b_valid", 64'(frm_valid), 64'd0);

    // 6: async reset mid-fill
    bf = nfr;
    push(8'h51); push(8'h52);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    push(8'h53);
    #1;
    chk("t6_valid", 64'(frm_valid), 64'd0);
    chk("t6_rinc", 64'(fifo_rinc), 64'd0);
    chk("t6_drop", 64'(frm_drop), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    push(8'h54); push(8'h55); push(8'h56);
    wait_nfr("t6_to", bf + 1);
    chk("t6_data", 64'(frames[bf]), 64'h56555453);
    chk("ovr_read", 64'(ovr), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
